// File: rtl/sveri_fixed_pkg.sv
// Shared fixed-point definitions for the activation blocks.
// Q(WIDTH-FRAC_BITS).FRAC_BITS words, signed and unsigned views.
package sveri_fixed_pkg;

  localparam int FXP_WIDTH     = 32;
  localparam int FXP_FRAC_BITS = 16;

  localparam logic [FXP_WIDTH-1:0] ONE =
    FXP_WIDTH'(1) << FXP_FRAC_BITS;

  typedef logic signed [FXP_WIDTH-1:0] fxp_t;
  typedef logic        [FXP_WIDTH-1:0] ufxp_t;

endpackage

// File: rtl/fxp_mul_signed_unsigned.sv
// Registered signed x unsigned multiply with enable.
// Product is kept at full width; the caller picks the scaling.
module fxp_mul_signed_unsigned #(
  parameter int A_WIDTH = 32,
  parameter int B_WIDTH = 17
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             en,
  input  logic signed [A_WIDTH-1:0]        a,
  input  logic        [B_WIDTH-1:0]        b,
  output logic signed [A_WIDTH+B_WIDTH:0]  p
);

  localparam int PW = A_WIDTH + B_WIDTH + 1;

  logic signed [PW-1:0] a_x;
  logic signed [PW-1:0] b_x;

  assign a_x = PW'(a);
  assign b_x = PW'({1'b0, b});

  always_ff @(posedge clk) begin
    if (rst) begin
      p <= '0;
    end else if (en) begin
      p <= a_x * b_x;
    end
  end

endmodule

// File: rtl/activation_sigmoid_backward.sv
// Sigmoid backward pass: out = g * a * (1 - a), 3-stage pipeline.
// One global advance enable; a stalled output freezes every stage.
module activation_sigmoid_backward
  import sveri_fixed_pkg::*;
#(
  parameter int WIDTH     = FXP_WIDTH,
  parameter int FRAC_BITS = FXP_FRAC_BITS,
  parameter int CNT_WIDTH = 16
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [WIDTH-1:0]        in_act,
  input  logic signed [WIDTH-1:0] in_grad,
  input  logic                    in_last,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic signed [WIDTH-1:0] out_grad,
  output logic                    out_last,
  output logic                    out_clamped,
  output logic [CNT_WIDTH-1:0]    clamp_count
);

  localparam int DW = FRAC_BITS + 1;
  localparam int PW = WIDTH + DW + 1;

  localparam logic [WIDTH-1:0] ONE_W = WIDTH'(1) << FRAC_BITS;
  localparam logic [DW-1:0]    ONE_D = DW'(1) << FRAC_BITS;

  logic            adv;
  logic            over;
  logic [DW-1:0]   a_c;
  logic [DW-1:0]   a_m;
  logic [2*DW-1:0] d_prod;
  logic [DW-1:0]   d;

  logic                    s1_valid;
  logic                    s1_last;
  logic                    s1_clamp;
  logic [DW-1:0]           s1_d;
  logic signed [WIDTH-1:0] s1_grad;

  logic                    s2_valid;
  logic                    s2_last;
  logic                    s2_clamp;
  logic signed [PW-1:0]    p;

  assign adv      = !out_valid || out_ready;
  assign in_ready = adv;

  // a*(1-a) peaks at ONE/4, so d fits in FRAC_BITS+1 bits
  assign over   = in_act > ONE_W;
  assign a_c    = over ? ONE_D : DW'(in_act);
  assign a_m    = ONE_D - a_c;
  assign d_prod = (2*DW)'(a_c) * (2*DW)'(a_m);
  assign d      = DW'(d_prod >> FRAC_BITS);

  fxp_mul_signed_unsigned #(
    .A_WIDTH (WIDTH),
    .B_WIDTH (DW)
  ) u_mul (
    .clk (clk),
    .rst (rst),
    .en  (adv),
    .a   (s1_grad),
    .b   (s1_d),
    .p   (p)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid    <= 1'b0;
      s1_last     <= 1'b0;
      s1_clamp    <= 1'b0;
      s1_d        <= '0;
      s1_grad     <= '0;
      s2_valid    <= 1'b0;
      s2_last     <= 1'b0;
      s2_clamp    <= 1'b0;
      out_valid   <= 1'b0;
      out_last    <= 1'b0;
      out_clamped <= 1'b0;
      out_grad    <= '0;
    end else if (adv) begin
      s1_valid    <= in_valid;
      s1_last     <= in_valid && in_last;
      s1_clamp    <= in_valid && over;
      s1_d        <= d;
      s1_grad     <= in_grad;
      s2_valid    <= s1_valid;
      s2_last     <= s1_last;
      s2_clamp    <= s1_clamp;
      out_valid   <= s2_valid;
      out_last    <= s2_last;
      out_clamped <= s2_clamp;
      out_grad    <= WIDTH'(p >>> FRAC_BITS);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      clamp_count <= '0;
    end else if (in_valid && adv && over && clamp_count != '1) begin
      clamp_count <= clamp_count + CNT_WIDTH'(1);
    end
  end

endmodule

// File: tb/tb_activation_sigmoid_backward.sv
// Bench for activation_sigmoid_backward: directed and random beats
// against a plain-arithmetic model, plus a 4-bit counter instance.
module tb_activation_sigmoid_backward;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic               rst;
  logic               in_valid;
  logic               in_ready;
  logic [31:0]        in_act;
  logic signed [31:0] in_grad;
  logic               in_last;
  logic               out_valid;
  logic               out_ready;
  logic signed [31:0] out_grad;
  logic               out_last;
  logic               out_clamped;
  logic [15:0]        clamp_count;

  logic               in_valid_s;
  logic               in_ready_s;
  logic [31:0]        in_act_s;
  logic signed [31:0] in_grad_s;
  logic               out_valid_s;
  logic signed [31:0] out_grad_s;
  logic               out_last_s;
  logic               out_clamped_s;
  logic [3:0]         clamp_count_s;

  activation_sigmoid_backward u_dut (
    .clk         (clk),
    .rst         (rst),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_act      (in_act),
    .in_grad     (in_grad),
    .in_last     (in_last),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_grad    (out_grad),
    .out_last    (out_last),
    .out_clamped (out_clamped),
    .clamp_count (clamp_count)
  );

  activation_sigmoid_backward #(.CNT_WIDTH(4)) u_sat (
    .clk         (clk),
    .rst         (rst),
    .in_valid    (in_valid_s),
    .in_ready    (in_ready_s),
    .in_act      (in_act_s),
    .in_grad     (in_grad_s),
    .in_last     (1'b0),
    .out_valid   (out_valid_s),
    .out_ready   (1'b1),
    .out_grad    (out_grad_s),
    .out_last    (out_last_s),
    .out_clamped (out_clamped_s),
    .clamp_count (clamp_count_s)
  );

  typedef struct {
    logic signed [31:0] g;
    logic               l;
    logic               c;
  } exp_t;

  exp_t q[$];
  int   checks = 0;
  int   errors = 0;
  int   cnt_exp = 0;
  bit   rand_done;

  function automatic logic signed [31:0] ref_grad(
    input longint act, input longint grad);
    longint ac, d, pr, r;
    ac = (act > 65536) ? 65536 : act;
    d  = (ac * (65536 - ac)) / 65536;
    pr = grad * d;
    r  = pr >>> 16;
    return r[31:0];
  endfunction

  task automatic chk(input string tag,
                     input logic [63:0] obs,
                     input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Called at a negedge; returns at the negedge after the accept edge.
  task automatic send(input logic [31:0] a,
                      input logic [31:0] g,
                      input logic l);
    int n;
    n = 0;
    in_valid = 1'b1;
    in_act   = a;
    in_grad  = g;
    in_last  = l;
    #1;
    while (!in_ready && n < 50) begin
      @(negedge clk);
      #1;
      n++;
    end
    if (n >= 50) chk("send_timeout", 64'(in_ready), 64'd1);
    q.push_back('{ref_grad(longint'(a), longint'($signed(g))),
                  l, a > 32'd65536});
    if (a > 32'd65536 && cnt_exp < 65535) cnt_exp++;
    @(negedge clk);
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (q.size() != 0 && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (n >= 100) chk("drain_timeout", 64'(q.size()), 64'd0);
  endtask

  // Output monitor: scoreboard pops and stall-hold checks
  logic               prev_stall = 1'b0;
  logic signed [31:0] held_g;
  logic               held_l;
  logic               held_c;

  always begin
    exp_t e;
    @(negedge clk);
    #2;
    if (rst) begin
      prev_stall = 1'b0;
    end else begin
      if (prev_stall) begin
        chk("hold_grad", 64'(out_grad), 64'(held_g));
        chk("hold_last", 64'(out_last), 64'(held_l));
        chk("hold_clamp", 64'(out_clamped), 64'(held_c));
      end
      if (out_valid && !out_ready) begin
        chk("stall_in_ready", 64'(in_ready), 64'd0);
        prev_stall = 1'b1;
        held_g = out_grad;
        held_l = out_last;
        held_c = out_clamped;
      end else begin
        prev_stall = 1'b0;
      end
      if (out_valid && out_ready) begin
        chk("beat_expected", 64'(q.size() != 0), 64'd1);
        if (q.size() != 0) begin
          e = q.pop_front();
          chk("out_grad", 64'(out_grad), 64'(e.g));
          chk("out_last", 64'(out_last), 64'(e.l));
          chk("out_clamped", 64'(out_clamped), 64'(e.c));
        end
      end
    end
  end

  initial begin
    logic [31:0] acts [8];
    logic [31:0] grads [8];
    rst        = 1'b1;
    in_valid   = 1'b0;
    in_act     = '0;
    in_grad    = '0;
    in_last    = 1'b0;
    out_ready  = 1'b1;
    in_valid_s = 1'b0;
    in_act_s   = '0;
    in_grad_s  = '0;
    rand_done  = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    #2;
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_out_grad", 64'(out_grad), 64'd0);
    chk("rst_out_last", 64'(out_last), 64'd0);
    chk("rst_out_clamped", 64'(out_clamped), 64'd0);
    chk("rst_clamp_count", 64'(clamp_count), 64'd0);
    chk("rst_in_ready", 64'(in_ready), 64'd1);
    @(negedge clk);

    // Latency: visible after the third edge counting the accept edge
    send(32'd32768, 32'd65536, 1'b0);
    #2;
    chk("lat_e1", 64'(out_valid), 64'd0);
    @(negedge clk);
    #2;
    chk("lat_e2", 64'(out_valid), 64'd0);
    @(negedge clk);
    #2;
    chk("lat_e3_valid", 64'(out_valid), 64'd1);
    chk("lat_e3_grad", 64'(out_grad), 64'd16384);
    drain();

    // Directed nominal, sign, rounding, endpoints, clamp
    @(negedge clk);
    send(32'd16384, 32'd131072, 1'b0);
    send(32'd32768, -32'sd65536, 1'b0);
    send(32'd32768, -32'sd1, 1'b0);
    send(32'd32768, 32'd1, 1'b0);
    send(32'd0, 32'd65536, 1'b0);
    send(32'd65536, 32'd65536, 1'b0);
    send(32'd70000, 32'd65536, 1'b1);
    #1;
    chk("cnt_one_clamp", 64'(clamp_count), 64'(cnt_exp));
    send(32'hFFFF_FFFF, -32'sd12345, 1'b0);
    #1;
    chk("cnt_two_clamp", 64'(clamp_count), 64'(cnt_exp));
    drain();

    // Backpressure: 8 beats, out_ready low for 5 cycles mid-stream
    for (int i = 0; i < 8; i++) begin
      acts[i]  = $urandom_range(0, 70000);
      grads[i] = $urandom_range(0, 32'h0200_0000) - 32'h0100_0000;
    end
    @(negedge clk);
    fork
      begin
        for (int i = 0; i < 8; i++) send(acts[i], grads[i], i == 7);
      end
      begin
        repeat (4) @(negedge clk);
        out_ready = 1'b0;
        repeat (5) @(negedge clk);
        out_ready = 1'b1;
      end
    join
    drain();
    chk("bp_cnt", 64'(clamp_count), 64'(cnt_exp));

    // Random beats with random backpressure
    @(negedge clk);
    fork
      begin
        for (int i = 0; i < 40; i++) begin
          send($urandom_range(0, 70000),
               $urandom_range(0, 32'h0200_0000) - 32'h0100_0000,
               $urandom_range(0, 7) == 0);
        end
        rand_done = 1'b1;
      end
      begin
        while (!rand_done) begin
          @(negedge clk);
          out_ready = $urandom_range(0, 3) != 0;
        end
        out_ready = 1'b1;
      end
    join
    drain();
    chk("rand_cnt", 64'(clamp_count), 64'(cnt_exp));

    // Reset with 3 beats in flight
    @(negedge clk);
    send(32'd70000, 32'd65536, 1'b0);
    send(32'd70001, 32'd65536, 1'b0);
    send(32'd70002, 32'd65536, 1'b0);
    rst = 1'b1;
    q.delete();
    cnt_exp = 0;
    @(negedge clk);
    rst = 1'b0;
    #2;
    chk("mid_rst_valid", 64'(out_valid), 64'd0);
    chk("mid_rst_count", 64'(clamp_count), 64'd0);
    @(negedge clk);
    send(32'd16384, 32'd131072, 1'b1);
    #2;
    chk("post_rst_e1", 64'(out_valid), 64'd0);
    @(negedge clk);
    #2;
    chk("post_rst_e2", 64'(out_valid), 64'd0);
    @(negedge clk);
    #2;
    chk("post_rst_valid", 64'(out_valid), 64'd1);
    chk("post_rst_grad", 64'(out_grad), 64'd24576);
    drain();

    // 4-bit counter saturation on the second instance
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (i == 10) chk("sat_mid", 64'(clamp_count_s), 64'd10);
      in_valid_s = 1'b1;
      in_act_s   = 32'd70000 + 32'(i);
      in_grad_s  = 32'd65536;
    end
    @(negedge clk);
    in_valid_s = 1'b0;
    #1;
    chk("sat_hold", 64'(clamp_count_s), 64'd15);
    repeat (4) @(negedge clk);
    chk("sat_stable", 64'(clamp_count_s), 64'd15);

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
